// File: rtl/hamming_encoder_serial.sv
// hamming_encoder_serial
// Collects serial data bits four at a time (d1..d4), encodes each nibble as a
// Hamming(7,4) codeword ordered p1,p2,d1,p4,d2,d3,d4, and shifts the codeword
// out p1 first. After each codeword, IDLE_GAP idle cycles are inserted.
// A one-entry pending register decouples input collection from transmission.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   s_in        serial data bit, taken when in_valid && in_ready
//   in_valid    qualifies s_in
//   in_ready    block can accept s_in this cycle
//   s_out       serial codeword bit (0 when out_valid is low)
//   out_valid   qualifies s_out
//   frame_start high with p1 of each codeword
//   busy        transmitter active or pending nibble held
//   overrun     sticky: a bit was offered while in_ready was low
module hamming_encoder_serial #(
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic s_in,
  input  logic in_valid,
  output logic in_ready,
  output logic s_out,
  output logic out_valid,
  output logic frame_start,
  output logic busy,
  output logic overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

  state_t      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  gap_q, gap_d;
  logic [6:0]  sr_q, sr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  nib_q, nib_d;
  logic [3:0]  pend_q, pend_d;
  logic        pend_full_q, pend_full_d;
  logic        overrun_q, overrun_d;
  logic        load;
  logic        accept;
  logic [6:0]  codeword;

  // pend_q = {d1,d2,d3,d4}
  always_comb begin
    codeword = {pend_q[3] ^ pend_q[2] ^ pend_q[0],
                pend_q[3] ^ pend_q[1] ^ pend_q[0],
                pend_q[3],
                pend_q[2] ^ pend_q[1] ^ pend_q[0],
                pend_q[2],
                pend_q[1],
                pend_q[0]};
  end

  // Transmitter: load is the single point where the pending nibble is
  // consumed, whether from IDLE, back-to-back at bit 6, or at the end of GAP.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sr_d    = sr_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_full_q) load = 1'b1;
      end
      SEND: begin
        sr_d  = {sr_q[5:0], 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd6) begin
          if (IDLE_GAP > 0) begin
            state_d = GAP;
            gap_d   = GAP_LAST;
          end else if (pend_full_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_q == 4'd0) begin
          if (pend_full_q) load = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = SEND;
      bit_d   = 3'd0;
      sr_d    = codeword;
    end
  end

  // A load on the same edge frees the pending slot, so the fourth bit can
  // still be taken and overwrite pending without stalling.
  assign in_ready = !((cnt_q == 2'd3) && pend_full_q && !load);
  assign accept   = in_valid && in_ready;

  always_comb begin
    cnt_d       = cnt_q;
    nib_d       = nib_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    overrun_d   = overrun_q | (in_valid & ~in_ready);
    if (load) pend_full_d = 1'b0;
    if (accept) begin
      if (cnt_q == 2'd3) begin
        pend_d      = {nib_q, s_in};
        pend_full_d = 1'b1;
        cnt_d       = 2'd0;
      end else begin
        nib_d = {nib_q[1:0], s_in};
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_q       <= '0;
      gap_q       <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      nib_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      nib_q       <= nib_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid   = (state_q == SEND);
  assign s_out       = (state_q == SEND) && sr_q[6];
  assign frame_start = (state_q == SEND) && (bit_q == 3'd0);
  assign busy        = (state_q != IDLE) || pend_full_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/hamming_encoder_serial.md
HAMMING_ENCODER_SERIAL -- requirements
Module: hamming_encoder_serial

Interface
REQ-001 SHALL have parameter IDLE_GAP, default 0: idle cycles inserted after each 7-bit codeword (legal 0..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port s_in  input  1  serial data bit, sampled only when in_valid and in_ready are both high.
REQ-005 SHALL have port in_valid  input  1  qualifies s_in.
REQ-006 SHALL have port in_ready  output  1  block can accept s_in this cycle.
REQ-007 SHALL have port s_out  output  1  serial codeword bit.
REQ-008 SHALL have port out_valid  output  1  qualifies s_out.
REQ-009 SHALL have port frame_start  output  1  high only with the first bit (p1) of each codeword.
REQ-010 SHALL have port busy  output  1  transmitter not in IDLE, or pending nibble held.
REQ-011 SHALL have port overrun  output  1  sticky; set when a bit is offered while in_ready is low.

Function
REQ-012 SHALL collect data bits in order d1,d2,d3,d4 using a 2-bit input counter (0..3) that advances only on accepted bits; gaps in in_valid are allowed.
REQ-013 SHALL, on the edge accepting d4, wrap the counter to 0 and write {d1..d4} into a one-entry pending register (pending_full=1).
REQ-014 SHALL encode p1=d1^d2^d4, p2=d1^d3^d4, p4=d2^d3^d4, codeword order p1,p2,d1,p4,d2,d3,d4, transmitted p1 first.
REQ-015 SHALL implement transmitter states IDLE, SEND (3-bit bit index 0..6), GAP (4-bit count).
REQ-016 IDLE: if pending_full, load codeword into 7-bit output shift register, clear pending, go to SEND bit 0; else stay.
REQ-017 SEND: drive one codeword bit per cycle with out_valid=1; frame_start=1 at bit 0 only.
REQ-018 SEND bit 6: IDLE_GAP>0 -> GAP; else pending_full -> reload, SEND bit 0 (back-to-back, no bubble); else IDLE.
REQ-019 GAP: out_valid=0 for exactly IDLE_GAP cycles; on last GAP cycle, pending_full -> reload into SEND bit 0, else IDLE.
REQ-020 Latency: d4 accepted on edge E with transmitter IDLE -> p1 appears on s_out with out_valid=1 after edge E+1.
REQ-021 s_out SHALL be 0 whenever out_valid is 0.
REQ-022 in_ready SHALL be 0 only when input counter=3 and pending_full=1 and no load occurs on the same edge; otherwise 1.
REQ-023 Simultaneous load and new nibble on one edge: pending SHALL hold the new nibble, pending_full stays 1, no overrun.
REQ-024 in_valid=1 with in_ready=0: bit discarded, counter unchanged, overrun set to 1 on that edge and held until reset.
REQ-025 busy SHALL equal (state!=IDLE) or pending_full.

Reset
REQ-026 reset=1 SHALL immediately force: state IDLE, counters 0, pending empty, s_out=0, out_valid=0, frame_start=0, busy=0, overrun=0, in_ready=1.
REQ-027 Reset asserted mid-collection or mid-codeword SHALL discard partial nibble and partial codeword; no further s_out bits after reset deasserts until 4 new bits are accepted.

Verification
REQ-028 Nibble d1..d4=1,0,1,1, IDLE_GAP=0 -> s_out 0,1,1,0,0,1,1 over 7 cycles, frame_start on first, starting edge after d4.
REQ-029 Nibbles 0000 then 1111 streamed continuously, IDLE_GAP=0 -> 14 contiguous valid bits 0000000 1111111, frame_start at bits 0 and 7.
REQ-030 Nibble 1000 twice, IDLE_GAP=3 -> 1110000, 3 cycles out_valid=0, 1110000.
REQ-031 in_valid held high continuously from reset for 16 bits, IDLE_GAP=15 -> in_ready drops at counter=3 while pending full, overrun=1 only if bits offered then, no codeword corrupted.
REQ-032 reset asserted at codeword bit 3 -> out_valid=0 and s_out=0 immediately; next 4 accepted bits 1011 produce exactly 0110011.
REQ-033 in_valid toggled 1,0,1,0,... with bits 1,0,1,1 -> same codeword as REQ-028; counter advances only on valid cycles.
